// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul_ctrl (with helper n_bit_adder)
// Brief    : Sequential unsigned NxN shift-and-add multiplier sharing one
//            ripple-carry adder across N iterations; 2N-bit product.
// Revision : 1.0 - initial release
// ============================================================================

module n_bit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] w_carry;

    assign w_carry[0] = c_in;

    generate
        for (genvar i = 0; i < N; i++) begin : g_fa
            assign s[i]           = x[i] ^ y[i] ^ w_carry[i];
            assign w_carry[i + 1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign co = w_carry[N];

endmodule

module shift_add_mul_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int                 c_CNT_W    = $clog2(N + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(N);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [N-1:0]       r_m_q,       w_m_d;
    logic [N-1:0]       r_acc_q,     w_acc_d;
    logic [N-1:0]       r_q_q,       w_q_d;
    logic [c_CNT_W-1:0] r_cnt_q,     w_cnt_d;
    logic [2*N-1:0]     r_product_q, w_product_d;
    logic               r_busy_q,    w_busy_d;
    logic               r_done_q,    w_done_d;

    logic [N-1:0]       w_y;
    logic [N-1:0]       w_sum;
    logic               w_co;
    logic [2*N-1:0]     w_shift;

    // Gating the operand keeps a single adder on the path instead of a result mux.
    assign w_y = r_m_q & {N{r_q_q[0]}};

    n_bit_adder #(
        .N (N)
    ) u_adder (
        .x    (r_acc_q),
        .y    (w_y),
        .c_in (1'b0),
        .s    (w_sum),
        .co   (w_co)
    );

    // Post-iteration {A,Q}: carry enters the top, Q's LSB falls off the bottom.
    generate
        if (N == 1) begin : g_shift_n1
            assign w_shift = {w_co, w_sum};
        end else begin : g_shift_wide
            assign w_shift = {w_co, w_sum, r_q_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_d   = r_state_q;
        w_m_d       = r_m_q;
        w_acc_d     = r_acc_q;
        w_q_d       = r_q_q;
        w_cnt_d     = r_cnt_q;
        w_product_d = r_product_q;
        w_busy_d    = 1'b0;
        w_done_d    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_m_d     = a;
                    w_q_d     = b;
                    w_acc_d   = '0;
                    w_cnt_d   = c_CNT_INIT;
                    w_state_d = S_ADD;
                    w_busy_d  = 1'b1;
                end
            end
            S_ADD: begin
                w_acc_d = w_shift[2*N-1:N];
                w_q_d   = w_shift[N-1:0];
                w_cnt_d = r_cnt_q - c_CNT_ONE;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_product_d = w_shift;
                    w_state_d   = S_DONE;
                    w_done_d    = 1'b1;
                end else begin
                    w_busy_d    = 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_m_q       <= '0;
            r_acc_q     <= '0;
            r_q_q       <= '0;
            r_cnt_q     <= '0;
            r_product_q <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_m_q       <= w_m_d;
            r_acc_q     <= w_acc_d;
            r_q_q       <= w_q_d;
            r_cnt_q     <= w_cnt_d;
            r_product_q <= w_product_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign product = r_product_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mul_ctrl
// Brief    : Scoreboard bench for shift_add_mul_ctrl at N=4, N=1 and N=8.
// Revision : 1.0 - initial release
// ============================================================================

module tb_shift_add_mul_ctrl;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start4, start1, start8;
    logic [3:0]  a4, b4;
    logic        a1, b1;
    logic [7:0]  a8, b8;
    logic        busy4, done4, busy1, done1, busy8, done8;
    logic [7:0]  prod4;
    logic [1:0]  prod1;
    logic [15:0] prod8;

    int   cyc;
    int   nchk;
    int   nerr;
    int   busy_run [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    shift_add_mul_ctrl #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    shift_add_mul_ctrl #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .product(prod1)
    );

    shift_add_mul_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nval(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push(input int i, input logic [15:0] p, input int c);
        exp_t e;
        e.prod = p;
        e.cyc  = c;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int i, input logic d, input logic bz, input logic [15:0] p);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (bz) busy_run[i]++;
        if (d) begin
            check($sformatf("busy_during_done_n%0d", nval(i)), {31'd0, bz}, 32'd0);
            case (i)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_done_n%0d: actual=done required=no_done (t=%0t)", nval(i), $time);
            end else begin
                check($sformatf("product_n%0d", nval(i)), {16'd0, p}, {16'd0, e.prod});
                check($sformatf("done_cycle_n%0d", nval(i)), cyc, e.cyc);
                check($sformatf("busy_cycles_n%0d", nval(i)), busy_run[i], nval(i));
            end
            busy_run[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_run = '{0, 0, 0};
        end else begin
            mon(0, done4, busy4, {8'd0, prod4});
            mon(1, done1, busy1, {14'd0, prod1});
            mon(2, done8, busy8, prod8);
        end
    end

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic [15:0] p);
        @(negedge clk);
        a4 = x; b4 = y; start4 = 1'b1;
        push(0, p, cyc + 1 + 4);
        @(negedge clk);
        start4 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic op1(input logic x, input logic y, input logic [15:0] p);
        @(negedge clk);
        a1 = x; b1 = y; start1 = 1'b1;
        push(1, p, cyc + 1 + 1);
        @(negedge clk);
        start1 = 1'b0;
        repeat (1) @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        push(2, p, cyc + 1 + 8);
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst = 1'b1;
        start4 = 1'b0; start1 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
        #12;
        check("reset_busy4", {31'd0, busy4}, 32'd0);
        check("reset_done4", {31'd0, done4}, 32'd0);
        check("reset_prod4", {24'd0, prod4}, 32'd0);
        check("reset_busy1", {31'd0, busy1}, 32'd0);
        check("reset_prod1", {30'd0, prod1}, 32'd0);
        check("reset_busy8", {31'd0, busy8}, 32'd0);
        check("reset_prod8", {16'd0, prod8}, 32'd0);
        rst = 1'b0;

        op4(4'd0, 4'd9, 16'd0);
        op4(4'd9, 4'd0, 16'd0);
        op4(4'd15, 4'd15, 16'd225);

        // Operands scrambled while the multiply is in flight.
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
        push(0, 16'd143, cyc + 1 + 4);
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(negedge clk);
        end

        // Start held high: accepts at E0, E6, E12.
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        push(0, 16'd15, cyc + 1 + 4);
        push(0, 16'd15, cyc + 1 + 10);
        push(0, 16'd15, cyc + 1 + 16);
        repeat (13) @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset during the second ADD cycle; no done expected.
        a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("busy_before_reset", {31'd0, busy4}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy4}, 32'd0);
        check("async_rst_done", {31'd0, done4}, 32'd0);
        check("async_rst_prod", {24'd0, prod4}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        op4(4'd2, 4'd3, 16'd6);

        op1(1'b1, 1'b1, 16'd1);
        op1(1'b0, 1'b1, 16'd0);
        op1(1'b1, 1'b0, 16'd0);

        op8(8'd255, 8'd255, 16'd65025);
        op8(8'd12, 8'd34, 16'd408);
        op8(8'd128, 8'd2, 16'd256);

        for (int k = 0; k < 4; k++) begin
            logic [3:0] x4, y4;
            logic [7:0] x8, y8;
            x4 = 4'($urandom); y4 = 4'($urandom);
            x8 = 8'($urandom); y8 = 8'($urandom);
            op4(x4, y4, 16'(x4) * 16'(y4));
            op8(x8, y8, 16'(x8) * 16'(y8));
        end

        for (int k = 0; k < 50 && (q0.size() + q1.size() + q2.size()) > 0; k++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check("outstanding_expected", q0.size() + q1.size() + q2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/shift_add_mul_ctrl.md
# shift_add_mul_ctrl

Sequential unsigned N×N multiplier controller that time-shares a single `n_bit_adder` (`n` = N, carry-in tied to 0) across N iterations using the shift-and-add algorithm. It accepts one operand pair per start request and returns a 2N-bit product with a one-cycle done pulse. It is the sequencing layer above the ripple-carry adder chain in the arithmetic datapath.

## Interface
- `N`, 4: operand width. Legal for N ≥ 1. The product is 2N bits and the adder instance width is N.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `a` in N: multiplicand (unsigned). Captured on the accepting edge.
- `b` in N: multiplier (unsigned). Captured on the accepting edge.
- `busy` out 1: high while in state ADD.
- `done` out 1: high for exactly one cycle (state DONE).
- `product` out 2N: result register. Updated only on entry to DONE and held until the next DONE entry or reset.

## Operation
- Internal registers:
  - M (N bits): multiplicand.
  - A (N bits): accumulator, upper half.
  - Q (N bits): multiplier, lower half.
  - cnt: width $clog2(N+1).
  - state ∈ {IDLE, ADD, DONE}.
- Adder hookup: x = A, y = M when Q[0] = 1, y = 0 otherwise. c_in = 0. The adder produces sum s and carry-out co. An AND-gated operand is used instead of a mux on the result.
- IDLE:
  - start = 1 → load M = a, Q = b, A = 0, cnt = N; go to ADD.
  - start = 0 → stay in IDLE.
- ADD, one iteration per edge:
  - A ← {co, s[N-1:1]}
  - Q ← {s[0], Q[N-1:1]}
  - cnt ← cnt − 1
  - When cnt = 1 at the edge, perform the final iteration, load product ← {co, s[N-1:1], s[0], Q[N-1:1]} (the post-shift {A,Q}), and go to DONE.
- DONE: unconditionally go to IDLE on the next edge.
- `start` is ignored in ADD and DONE. There is no queueing, so a request held high is re-sampled once back in IDLE.
- `a` and `b` may change freely after the accepting edge without affecting the operation in flight.
- Arithmetic: unsigned only. The full 2N-bit product is always exact, so there is no overflow. co is never lost because it shifts into A[N-1].
- Reset (any time, including mid-ADD): immediately go to IDLE and clear A, Q, M, cnt and product to 0. `busy` = 0, `done` = 0. The operation in flight is discarded and no done pulse is produced.
- Reset values: `busy` = 0, `done` = 0, `product` = 0.

## Timing
- The accepting edge E0 is the edge where state = IDLE and start = 1.
- `busy` = 1 from E0 until E_N, which is N cycles.
- `product` becomes valid and `done` = 1 at E_N. `done` deasserts at E_(N+1).
- Latency from the accepting edge to the done edge is N cycles.
- The earliest next accepting edge is E_(N+2), so back-to-back throughput is one multiply per N+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `busy`, `done` and `product` are registered or decoded directly from state. There is no combinational path from `start`, `a` or `b` to any output.
- Critical path: the N-bit ripple through `n_bit_adder` plus the operand AND gating, from register to register.
- N = 1 boundary: cnt = 1 at load, so ADD lasts one cycle and `done` is at E1.

## Test plan
- Zero operand, N=4: a=0, b=9, start pulse → `busy` for 4 cycles, then `done` pulse with `product` = 0. Repeat with a=9, b=0 → `product` = 0.
- Max operands and carry-out path, N=4: a=15, b=15 → `product` = 225 (8'hE1) exactly 4 cycles after the accepting edge, with a one-cycle `done`.
- General value with operands changed mid-op: a=13, b=11 accepted, then a/b driven to random values during ADD → `product` = 143 (8'h8F), unaffected by the changes.
- Start ignored while busy, and continuous start: hold `start` = 1 with a=3, b=5 → `product` = 15 each time, `done` pulses every 6 cycles, and the inputs are re-sampled only in IDLE.
- Reset mid-operation: start a=7, b=6, assert `rst` asynchronously during the 2nd ADD cycle → `busy`, `done` and `product` go to 0 immediately without waiting for a clock, and no `done` follows. The next start with a=2, b=3 → `product` = 6.
- Parameter sweep: N=1 (1×1 = 1, `done` one cycle after accept) and N=8 (255×255 = 65025, `done` 8 cycles after accept). Randomized operands compared against a×b.
